tdm_demultiplexer: RTL and testbench

- Receiving end of the 4:1 lane multiplexer: takes a time-division-multiplexed beat stream and redistributes it into four registered output lanes.
- Each frame carries four beats, in lane order 0, 1, 2, 3.
- All four lanes update together when a frame completes, and a one-cycle valid pulse marks the update.
- Framing violations are flagged, and the block resynchronises on the next frame start.

---
 rtl/tdm_demultiplexer_if.sv | 29 ++
 rtl/tdm_demultiplexer.sv | 137 +++++++++++++
 tb/tb_tdm_demultiplexer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tdm_demultiplexer_if.sv
// Bus bundle for the 4-lane TDM demultiplexer: beat input side plus the
// four registered output lanes, valid/error pulses and the slot select.
interface tdm_demultiplexer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             frame_start;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic             out_valid;
    logic             select0;
    logic             select1;
    logic             frame_error;

    // Beat source / lane consumer side.
    modport master (
        output in, in_valid, frame_start,
        input  out0, out1, out2, out3, out_valid, select0, select1, frame_error
    );

    // Demultiplexer side.
    modport slave (
        input  in, in_valid, frame_start,
        output out0, out1, out2, out3, out_valid, select0, select1, frame_error
    );
endinterface

// File: rtl/tdm_demultiplexer.sv
// tdm_demultiplexer: collects a 4-beat TDM frame (lanes 0..3) into shadow
// registers and publishes all four lanes at once with a one-cycle out_valid.
// An early frame_start aborts the partial frame with a frame_error pulse.
// Optional mid-frame gap timeout: define TDM_DEMUX_TIMEOUT_EN.
module tdm_demultiplexer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tdm_demultiplexer_if.slave   bus
);
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECEIVE = 1'b1
    } state_e;

    localparam int unsigned SLOT_W = 2;
    localparam int unsigned GAP_W  = 8;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    // Lane 3 goes straight to the output, so only lanes 0..2 need shadowing.
    logic [WIDTH-1:0]    shadow_q [3];
    logic [WIDTH-1:0]    shadow_d [3];
    logic [WIDTH-1:0]    out_q [4];
    logic [WIDTH-1:0]    out_d [4];
    logic                out_valid_q, out_valid_d;
    logic                frame_error_q, frame_error_d;

`ifdef TDM_DEMUX_TIMEOUT_EN
    logic [GAP_W-1:0]    gap_q, gap_d;
`else
    logic                unused_timeout;
    assign unused_timeout = (TIMEOUT == 0) || (GAP_W == 0);
`endif

    // Next-state: frame assembly, completion, restart and optional timeout.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        out_d         = out_q;
        out_valid_d   = 1'b0;
        frame_error_d = 1'b0;
`ifdef TDM_DEMUX_TIMEOUT_EN
        gap_d         = gap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Stray beats without frame_start are silently dropped.
                if (bus.in_valid && bus.frame_start) begin
                    shadow_d[0] = bus.in;
                    slot_d      = SLOT_W'(1);
                    state_d     = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (bus.in_valid) begin
`ifdef TDM_DEMUX_TIMEOUT_EN
                    gap_d = '0;
`endif
                    if (bus.frame_start) begin
                        // Early restart: drop partial frame, beat becomes lane 0.
                        frame_error_d = 1'b1;
                        shadow_d[0]   = bus.in;
                        slot_d        = SLOT_W'(1);
                    end else if (slot_q == SLOT_W'(3)) begin
                        out_d[0]    = shadow_q[0];
                        out_d[1]    = shadow_q[1];
                        out_d[2]    = shadow_q[2];
                        out_d[3]    = bus.in;
                        out_valid_d = 1'b1;
                        slot_d      = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        case (slot_q)
                            SLOT_W'(1): shadow_d[1] = bus.in;
                            SLOT_W'(2): shadow_d[2] = bus.in;
                            default:    shadow_d[0] = bus.in;
                        endcase
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
`ifdef TDM_DEMUX_TIMEOUT_EN
                else if (gap_q == GAP_W'(TIMEOUT - 1)) begin
                    // Gap limit reached with no beat this cycle: abort frame.
                    frame_error_d = 1'b1;
                    slot_d        = '0;
                    gap_d         = '0;
                    state_d       = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            slot_q        <= '0;
            out_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
            for (int i = 0; i < 4; i++) out_q[i]    <= '0;
`ifdef TDM_DEMUX_TIMEOUT_EN
            gap_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            out_valid_q   <= out_valid_d;
            frame_error_q <= frame_error_d;
            shadow_q      <= shadow_d;
            out_q         <= out_d;
`ifdef TDM_DEMUX_TIMEOUT_EN
            gap_q         <= gap_d;
`endif
        end
    end

    assign bus.out0        = out_q[0];
    assign bus.out1        = out_q[1];
    assign bus.out2        = out_q[2];
    assign bus.out3        = out_q[3];
    assign bus.out_valid   = out_valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.select0     = slot_q[0];
    assign bus.select1     = slot_q[1];
endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Testbench for tdm_demultiplexer: directed frames from the test plan plus
// random beat streams, checked every cycle against a queue-based frame model.
module tb_tdm_demultiplexer;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned TIMEOUT = 4;

    logic clk;
    logic rst_n;

    tdm_demultiplexer_if #(.WIDTH(WIDTH)) bus ();

    tdm_demultiplexer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is a list of beats; it is published at four.
    logic             m_in_frame;
    logic [WIDTH-1:0] m_part [$];
    logic [WIDTH-1:0] m_out  [4];
    logic             m_valid;
    logic             m_err;
    int               m_gap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_part.delete();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_gap   = 0;
    endtask

    task automatic model_step(input logic v, input logic fs, input logic [WIDTH-1:0] d);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!m_in_frame) begin
            if (v && fs) begin
                m_part.delete();
                m_part.push_back(d);
                m_in_frame = 1'b1;
                m_gap = 0;
            end
        end else if (v) begin
            m_gap = 0;
            if (fs) begin
                m_err = 1'b1;
                m_part.delete();
                m_part.push_back(d);
            end else begin
                m_part.push_back(d);
                if (m_part.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_out[i] = m_part[i];
                    m_valid = 1'b1;
                    m_part.delete();
                    m_in_frame = 1'b0;
                end
            end
        end else begin
`ifdef TDM_DEMUX_TIMEOUT_EN
            m_gap++;
            if (m_gap == int'(TIMEOUT)) begin
                m_err = 1'b1;
                m_part.delete();
                m_in_frame = 1'b0;
                m_gap = 0;
            end
`endif
        end
    endtask

    task automatic check_all(input string where);
        int sel;
        sel = m_in_frame ? m_part.size() : 0;
        check({where, ".out0"}, 32'(bus.out0), 32'(m_out[0]));
        check({where, ".out1"}, 32'(bus.out1), 32'(m_out[1]));
        check({where, ".out2"}, 32'(bus.out2), 32'(m_out[2]));
        check({where, ".out3"}, 32'(bus.out3), 32'(m_out[3]));
        check({where, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({where, ".frame_error"}, 32'(bus.frame_error), 32'(m_err));
        check({where, ".select"}, 32'({bus.select1, bus.select0}), 32'(sel));
    endtask

    // One clock cycle: drive, clock, advance model, sample 1 time unit later.
    task automatic beat(input logic v, input logic fs, input logic [WIDTH-1:0] d, input string where);
        bus.in_valid    = v;
        bus.frame_start = fs;
        bus.in          = d;
        @(posedge clk);
        model_step(v, fs, d);
        #1;
        check_all(where);
    endtask

    task automatic idle(input int n, input string where);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00, where);
    endtask

    initial begin
        logic [WIDTH-1:0] bytes4 [4];
        rst_n           = 1'b0;
        bus.in          = '0;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(10, "post_reset_idle");

        // Basic frame with select sequence 0,1,2,3 then 0.
        beat(1'b1, 1'b1, 8'hA1, "basic_b0");
        beat(1'b1, 1'b0, 8'hB2, "basic_b1");
        beat(1'b1, 1'b0, 8'hC3, "basic_b2");
        beat(1'b1, 1'b0, 8'hD4, "basic_b3");
        check("basic_valid_abs", 32'(bus.out_valid), 32'd1);
        check("basic_out3_abs", 32'(bus.out3), 32'hD4);
        idle(2, "basic_after");

        // Stray beat in IDLE, then a gapped frame.
        beat(1'b1, 1'b0, 8'h55, "stray");
        bytes4 = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, i == 0, bytes4[i], "gapped_beat");
            if (i < 3) idle(3, "gapped_gap");
        end
        check("gapped_out0_abs", 32'(bus.out0), 32'h01);
        idle(1, "gapped_after");

        // Early restart.
        beat(1'b1, 1'b1, 8'h10, "restart_a");
        beat(1'b1, 1'b0, 8'h11, "restart_b");
        beat(1'b1, 1'b1, 8'h20, "restart_c");
        check("restart_err_abs", 32'(bus.frame_error), 32'd1);
        beat(1'b1, 1'b0, 8'h21, "restart_d");
        beat(1'b1, 1'b0, 8'h22, "restart_e");
        beat(1'b1, 1'b0, 8'h23, "restart_f");
        check("restart_out0_abs", 32'(bus.out0), 32'h20);

        // Back-to-back frames, no error between them.
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++)
                beat(1'b1, i == 0, 8'(8'h40 + 16 * f + i), "b2b");

        // Reset mid-frame: outputs clear asynchronously.
        beat(1'b1, 1'b1, 8'h99, "mid_a");
        beat(1'b1, 1'b0, 8'h98, "mid_b");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 1'b1, 8'h0F, "after_reset");
        beat(1'b1, 1'b0, 8'h0E, "after_reset");
        beat(1'b1, 1'b0, 8'h0D, "after_reset");
        beat(1'b1, 1'b0, 8'h0C, "after_reset");
        check("after_reset_out3_abs", 32'(bus.out3), 32'h0C);

`ifdef TDM_DEMUX_TIMEOUT_EN
        beat(1'b1, 1'b1, 8'h77, "timeout_start");
        idle(4, "timeout_idle");
        beat(1'b1, 1'b1, 8'h78, "timeout_start2");
        idle(3, "timeout_short");
        beat(1'b1, 1'b0, 8'h79, "timeout_beat_in_time");
        idle(2, "timeout_tail");
`endif

        // Random beat stream.
        for (int n = 0; n < 3000; n++) begin
            logic v;
            logic fs;
            v  = ($urandom_range(0, 3) != 0);
            fs = ($urandom_range(0, 5) == 0);
            beat(v, fs, 8'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
